fibonacci_gen: RTL and testbench
================================

// Module: fibonacci_gen
// PURPOSE
//   Fibonacci sequence engine that consumes the Wishbone control block's outputs:
//   clock_op (step-rate divider) and switch_out (run/stop).
//   Drives the current term onto io_out[37:8]; the control block reads it back
//   through buf_io_out.
//   Raises interrupt pulses toward the Caravel user_irq lines.
// PARAMETERS
//   WIDTH        30  term width in bits; drives io_out[WIDTH+7:8]
//   CLOCK_WIDTH  6   width of clock_op; must match the control block
//   IO_PADS      38  pad count (`MPRJ_IO_PADS)
// PORTS
//   wb_clk_i   in   1            system clock
//   wb_rst_i   in   1            async reset, active-high
//   switch_in  in   1            run enable (from switch_out); 1 = run
//   clock_op   in   CLOCK_WIDTH  step period in clocks; 0 is treated as 1
//   io_out     out  IO_PADS      {term, 8'b0}
//   io_oeb     out  IO_PADS      {WIDTH{1'b0}, 8'hFF}: upper pads driven, low 8 are inputs
//   irq_out    out  3            [0] step pulse, [1] wrap pulse, [2] stopped level
// BEHAVIOUR
// - Reset (async assert, sync release). Values held while reset is asserted:
//   - a=0, b=1, prescaler cnt=0
//   - io_out=0, irq_out=3'b000
//   - io_oeb takes its constant value immediately.
//   - Reset mid-run discards the sequence; no irq pulse is produced.
// - Prescaler:
//   - limit = (clock_op==0) ? 1 : clock_op.
//   - While switch_in=1: if cnt >= limit-1, then tick=1 and cnt<=0; else cnt<=cnt+1.
//   - The >= compare means lowering clock_op mid-count ticks on the next cycle
//     and never skips the wrap.
//   - switch_in=0: cnt<=0, tick=0, a/b hold, io_out holds the current term.
//     Re-enable resumes from the held term; the first tick comes after limit cycles.
// - Step on tick:
//   - sum = {1'b0,a} + {1'b0,b}, WIDTH+1 bits.
//   - sum[WIDTH]=0: a<=b, b<=sum[WIDTH-1:0].
//   - sum[WIDTH]=1 (overflow): a<=0, b<=1. Sequence restarts at 0.
// - Output: io_out[WIDTH+7:8] = a (registered, so zero extra latency after the
//   state update); io_out[7:0] = 0.
//   - Term sequence: 0,1,1,2,3,5,... up to 433494437 (F43), then 0.
// - irq_out (registered, one-cycle pulses):
//   - [0] = 1 the cycle after any tick.
//   - [1] = 1 the cycle after an overflow tick; [0] is also 1 that cycle.
//   - [2] = ~switch_in, registered. It is 0 during reset.
// - Simultaneous events:
//   - Tick on the same edge switch_in falls: the step still completes if switch_in
//     was 1 when sampled. Sampling is synchronous, so the last step is not lost.
// CONFIGURATION
//   FIBONACCI_IRQ_EN
//   - Defined: irq_out behaves as above.
//   - Undefined: irq_out is constant 3'b000 and the irq registers are not
//     synthesized. The sequence and io_out are unchanged.
// STRUCTURE
//   - Shared package/header fib_pkg.vh:
//     - FIB_WIDTH=30, FIB_LSB=8
//     - IRQ_STEP=0, IRQ_WRAP=1, IRQ_STOP=2
//     - wrap term constant FIB_LAST=30'd433494437
//   - One sub-module: fib_prescaler (cnt, limit, tick). The adder and state
//     registers live in the top.
// TESTING
// 1. Reset with clock_op=1, switch_in=1, release.
//    -> io_out[37:8] = 0,1,1,2,3,5,8,13 on successive clocks; irq_out[0] high each cycle.
// 2. clock_op=4.
//    -> term advances exactly every 4 clocks; irq[0] high 1 of every 4 cycles.
//    clock_op=0 -> behaves as 1.
// 3. Run to F43 (433494437).
//    -> next tick yields 0 with irq_out=3'b011 for one cycle; then 1,1,2 follow.
// 4. At term 21, drop switch_in for 10 cycles.
//    -> io_out holds 21 and irq[2]=1.
//    Raise switch_in with clock_op=3 -> 34 appears 3 clocks later, irq[2]=0.
// 5. clock_op=40, cnt at 20, write clock_op=2.
//    -> tick on the next clock, then every 2 clocks.
// 6. Assert wb_rst_i asynchronously mid-run at term 144.
//    -> io_out=0 and irq_out=0 immediately.
//    Build without FIBONACCI_IRQ_EN and rerun 1 and 3 -> irq_out stays 0, terms identical.

Source files
------------

// File: rtl/fibonacci_gen_pkg.sv
// Shared widths, pad layout and irq bit positions for the Fibonacci engine.
package fibonacci_gen_pkg;

  localparam int unsigned FIB_WIDTH   = 30;
  localparam int unsigned FIB_LSB     = 8;
  localparam int unsigned CLOCK_WIDTH = 6;
  localparam int unsigned IO_PADS     = FIB_WIDTH + FIB_LSB;

  localparam int unsigned IRQ_STEP = 0;
  localparam int unsigned IRQ_WRAP = 1;
  localparam int unsigned IRQ_STOP = 2;

  // Largest term before the sum overflows FIB_WIDTH bits (F43).
  localparam logic [FIB_WIDTH-1:0] FIB_LAST = 30'd433494437;

endpackage

// File: rtl/fibonacci_gen_if.sv
// Control inputs and pad/irq outputs of the Fibonacci engine.
interface fibonacci_gen_if;
  import fibonacci_gen_pkg::*;

  logic                   switch_in;
  logic [CLOCK_WIDTH-1:0] clock_op;
  logic [IO_PADS-1:0]     io_out;
  logic [IO_PADS-1:0]     io_oeb;
  logic [2:0]             irq_out;

  modport master (
    output switch_in, clock_op,
    input  io_out, io_oeb, irq_out
  );

  modport slave (
    input  switch_in, clock_op,
    output io_out, io_oeb, irq_out
  );

endinterface

// File: rtl/fibonacci_gen_prescaler.sv
// Step-rate divider: one tick every max(clock_op,1) enabled clocks.
module fibonacci_gen_prescaler
  import fibonacci_gen_pkg::*;
(
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   enable,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  output logic                   tick
);

  logic [CLOCK_WIDTH-1:0] cnt_q, cnt_d, limit_m1;

  // >= rather than == so a lowered clock_op ticks at once instead of wrapping the counter.
  always_comb begin
    limit_m1 = (clock_op == '0) ? '0 : clock_op - CLOCK_WIDTH'(1);
    tick     = enable && (cnt_q >= limit_m1);
    cnt_d    = (!enable || tick) ? '0 : cnt_q + CLOCK_WIDTH'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fibonacci_gen.sv
// Fibonacci term generator driving io_out[37:8]; restarts at 0 after F43.
// Define FIBONACCI_IRQ_EN to build the step/wrap/stop irq registers.
module fibonacci_gen
  import fibonacci_gen_pkg::*;
(
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  fibonacci_gen_if.slave  bus
);

  logic                 tick;
  logic                 wrap;
  logic [FIB_WIDTH:0]   sum;
  logic [FIB_WIDTH-1:0] a_q, b_q;

  fibonacci_gen_prescaler u_prescaler (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .enable   (bus.switch_in),
    .clock_op (bus.clock_op),
    .tick     (tick)
  );

  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q};
    wrap = sum[FIB_WIDTH];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_q <= '0;
      b_q <= FIB_WIDTH'(1);
    end else if (tick) begin
      if (wrap) begin
        a_q <= '0;
        b_q <= FIB_WIDTH'(1);
      end else begin
        a_q <= b_q;
        b_q <= sum[FIB_WIDTH-1:0];
      end
    end
  end

  assign bus.io_out = {a_q, {FIB_LSB{1'b0}}};
  assign bus.io_oeb = {{FIB_WIDTH{1'b0}}, {FIB_LSB{1'b1}}};

`ifdef FIBONACCI_IRQ_EN
  logic [2:0] irq_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q <= '0;
    end else begin
      irq_q[IRQ_STEP] <= tick;
      irq_q[IRQ_WRAP] <= tick & wrap;
      irq_q[IRQ_STOP] <= ~bus.switch_in;
    end
  end

  assign bus.irq_out = irq_q;
`else
  assign bus.irq_out = 3'b000;
`endif

endmodule

// File: tb/tb_fibonacci_gen.sv
// Directed bench for fibonacci_gen: vector table plus reset and wrap sequences.
module tb_fibonacci_gen;
  import fibonacci_gen_pkg::*;

  typedef struct {
    logic        sw;
    logic [5:0]  cop;
    int unsigned term;
    logic [2:0]  irq;
  } vec_t;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  fibonacci_gen_if bus ();

  fibonacci_gen dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [2:0] expi(input logic [2:0] x);
`ifdef FIBONACCI_IRQ_EN
    return x;
`else
    return 3'b000;
`endif
  endfunction

  function automatic void add(input logic sw, input logic [5:0] cop, input int unsigned term,
                              input logic [2:0] irq);
    vec_t v;
    v.sw = sw; v.cop = cop; v.term = term; v.irq = expi(irq);
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic sw, input logic [5:0] cop,
                                input int unsigned term, input logic [2:0] irq);
    for (int i = 0; i < n; i++) add(sw, cop, term, irq);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic clk_step;
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [63:0] term_now();
    logic [FIB_WIDTH-1:0] t;
    t = bus.io_out[IO_PADS-1:FIB_LSB];
    return 64'(t);
  endfunction

  // Runs n steps at clock_op=1 from term 0, checking every term against the textbook sequence.
  task automatic run_seq(input int n, input string tag);
    longint unsigned ea, eb, tmp;
    logic [2:0] ei;
    ea = 0; eb = 1;
    for (int k = 1; k <= n; k++) begin
      clk_step();
      if (ea == 64'(FIB_LAST)) begin
        ea = 0; eb = 1; ei = 3'b011;
      end else begin
        tmp = ea + eb; ea = eb; eb = tmp; ei = 3'b001;
      end
      check({tag, "_term"}, term_now(), ea);
      check({tag, "_irq"}, 64'(bus.irq_out), 64'(expi(ei)));
      if (k == 43) check({tag, "_f43"}, term_now(), 64'(FIB_LAST));
    end
  endtask

  initial begin
    logic [IO_PADS-1:0] oeb_exp;
    oeb_exp = {{FIB_WIDTH{1'b0}}, 8'hFF};

    // Test 1: clock_op=1 from reset
    add(1, 1, 1, 3'b001); add(1, 1, 1, 3'b001); add(1, 1, 2, 3'b001); add(1, 1, 3, 3'b001);
    add(1, 1, 5, 3'b001); add(1, 1, 8, 3'b001); add(1, 1, 13, 3'b001); add(1, 1, 21, 3'b001);
    // Test 4: stop at 21, resume with clock_op=3
    add_n(10, 0, 3, 21, 3'b100);
    add(1, 3, 21, 3'b000); add(1, 3, 21, 3'b000); add(1, 3, 34, 3'b001);
    // Test 2: clock_op=4, then clock_op=0 acting as 1
    add_n(3, 1, 4, 34, 3'b000); add(1, 4, 55, 3'b001);
    add_n(3, 1, 4, 55, 3'b000); add(1, 4, 89, 3'b001);
    add(1, 0, 144, 3'b001); add(1, 0, 233, 3'b001);
    // Test 5: clock_op=40 to cnt 20, then lower to 2
    add_n(20, 1, 40, 233, 3'b000);
    add(1, 2, 377, 3'b001); add(1, 2, 377, 3'b000); add(1, 2, 610, 3'b001);

    wb_rst_i      = 1'b1;
    bus.switch_in = 1'b1;
    bus.clock_op  = 6'd1;
    clk_step();
    clk_step();
    check("rst_io_out", 64'(bus.io_out), 64'd0);
    check("rst_irq", 64'(bus.irq_out), 64'd0);
    check("rst_io_oeb", 64'(bus.io_oeb), 64'(oeb_exp));
    wb_rst_i = 1'b0;
    check("start_term", term_now(), 64'd0);

    foreach (vecs[i]) begin
      bus.switch_in = vecs[i].sw;
      bus.clock_op  = vecs[i].cop;
      clk_step();
      check($sformatf("vec%0d_term", i), term_now(), 64'(vecs[i].term));
      check($sformatf("vec%0d_irq", i), 64'(bus.irq_out), 64'(vecs[i].irq));
    end
    check("io_oeb_run", 64'(bus.io_oeb), 64'(oeb_exp));
    check("io_out_low", 64'(bus.io_out[FIB_LSB-1:0]), 64'd0);

    // Test 6: async reset mid-run at term 144
    bus.switch_in = 1'b1;
    bus.clock_op  = 6'd1;
    wb_rst_i      = 1'b1;
    clk_step();
    wb_rst_i = 1'b0;
    run_seq(12, "pre_rst");
    #3 wb_rst_i = 1'b1;
    #1;
    check("async_rst_term", term_now(), 64'd0);
    check("async_rst_irq", 64'(bus.irq_out), 64'd0);
    bus.switch_in = 1'b0;
    clk_step();
    clk_step();
    check("rst_stop_irq", 64'(bus.irq_out), 64'd0);
    check("rst_hold_term", term_now(), 64'd0);
    bus.switch_in = 1'b1;
    wb_rst_i      = 1'b0;

    // Test 3: run through F43 and the wrap to 0, 1, 1, 2
    run_seq(47, "wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
